// File: rtl/vip_rgb_ycbcr_conv.sv
// RGB to YCbCr converter: BT.601/BT.709 chosen once per frame, saturating outputs.
// Define YCBCR_422_EN to add a Cb/Cr pair-averaging stage (latency 4 instead of 3).
module vip_rgb_ycbcr_conv #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              per_img_vsync,
    input  logic              per_img_href,
    input  logic [DATA_W-1:0] per_img_red,
    input  logic [DATA_W-1:0] per_img_green,
    input  logic [DATA_W-1:0] per_img_blue,
    output logic              post_img_vsync,
    output logic              post_img_href,
    output logic [DATA_W-1:0] post_img_Y,
    output logic [DATA_W-1:0] post_img_Cb,
    output logic [DATA_W-1:0] post_img_Cr,
    output logic              mode_active
);
    localparam int SW = DATA_W + 11;
`ifdef YCBCR_422_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam logic signed [SW-1:0] ROUND = SW'(128);
    localparam logic signed [SW-1:0] C_OFF = SW'(1 << (DATA_W + 7));
    localparam logic signed [SW-1:0] MAX_S = SW'((1 << DATA_W) - 1);

    // Products are ordered Y(R,G,B), Cb(R,G,B), Cr(R,G,B).
    function automatic logic signed [SW-1:0] coef(input logic m, input int idx);
        int c;
        case (idx)
            0:       c = m ? 54   : 77;
            1:       c = m ? 183  : 150;
            2:       c = m ? 19   : 29;
            3:       c = m ? -29  : -43;
            4:       c = m ? -99  : -85;
            5:       c = 128;
            6:       c = 128;
            7:       c = m ? -116 : -107;
            8:       c = m ? -12  : -21;
            default: c = 0;
        endcase
        return SW'(c);
    endfunction

    function automatic logic [DATA_W-1:0] round_clamp(input logic signed [SW-1:0] s,
                                                      input logic chroma);
        logic signed [SW-1:0] t;
        t = s + ROUND;
        if (chroma) t = t + C_OFF;
        t = t >>> 8;
        if (t < 0) return '0;
        else if (t > MAX_S) return '1;
        else return t[DATA_W-1:0];
    endfunction

    logic              vsync_prev_q, vsync_prev_d;
    logic              frame_mode_q, frame_mode_d;
    logic              vs_rise, pix_mode;
    logic [LAT-1:0]    vs_q, vs_d, hs_q, hs_d;
    logic [LAT-2:0]    rise_q, rise_d, md_q, md_d;
    logic              mode_active_q, mode_active_d;

    // A vsync already high out of reset counts as a frame start, since prev resets to 0.
    always_comb begin
        vs_rise       = per_img_vsync & ~vsync_prev_q;
        pix_mode      = vs_rise ? mode : frame_mode_q;
        vsync_prev_d  = per_img_vsync;
        frame_mode_d  = pix_mode;
        vs_d          = {vs_q[LAT-2:0], per_img_vsync};
        hs_d          = {hs_q[LAT-2:0], per_img_href};
        rise_d        = {rise_q[LAT-3:0], vs_rise};
        md_d          = {md_q[LAT-3:0], pix_mode};
        mode_active_d = rise_q[LAT-2] ? md_q[LAT-2] : mode_active_q;
    end

    logic signed [SW-1:0] comp_ext [3];
    logic signed [SW-1:0] prod_d [9];
    logic signed [SW-1:0] prod_q [9];
    logic signed [SW-1:0] sum_d [3];
    logic signed [SW-1:0] sum_q [3];
    logic [DATA_W-1:0]    ycc_d [3];
    logic [DATA_W-1:0]    ycc_q [3];

    assign comp_ext[0] = signed'(SW'(per_img_red));
    assign comp_ext[1] = signed'(SW'(per_img_green));
    assign comp_ext[2] = signed'(SW'(per_img_blue));

    for (genvar gi = 0; gi < 9; gi++) begin : g_prod
        assign prod_d[gi] = coef(pix_mode, gi) * comp_ext[gi % 3];
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign sum_d[gi] = prod_q[3*gi] + prod_q[3*gi+1] + prod_q[3*gi+2];
        assign ycc_d[gi] = round_clamp(sum_q[gi], gi != 0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev_q  <= 1'b0;
            frame_mode_q  <= 1'b0;
            vs_q          <= '0;
            hs_q          <= '0;
            rise_q        <= '0;
            md_q          <= '0;
            mode_active_q <= 1'b0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= '0;
                ycc_q[i] <= '0;
            end
        end else begin
            vsync_prev_q  <= vsync_prev_d;
            frame_mode_q  <= frame_mode_d;
            vs_q          <= vs_d;
            hs_q          <= hs_d;
            rise_q        <= rise_d;
            md_q          <= md_d;
            mode_active_q <= mode_active_d;
            for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= sum_d[i];
                ycc_q[i] <= ycc_d[i];
            end
        end
    end

`ifdef YCBCR_422_EN
    logic              parity_q, parity_d, pair_now, odd_now;
    logic [DATA_W-1:0] avg_d [2];
    logic [DATA_W-1:0] avg_q [2];
    logic [DATA_W-1:0] out_d [3];
    logic [DATA_W-1:0] out_q [3];

    // An even pixel at stage 3 pairs with the pixel being clamped behind it (ycc_d);
    // the odd partner reuses that average one cycle later.
    always_comb begin
        parity_d = (hs_q[1] & hs_q[2]) ? ~parity_q : 1'b0;
        pair_now = hs_q[2] & ~parity_q & hs_q[1];
        odd_now  = hs_q[2] & parity_q;
        out_d[0] = ycc_q[0];
        for (int i = 0; i < 2; i++) begin
            avg_d[i]   = DATA_W'(({1'b0, ycc_q[i+1]} + {1'b0, ycc_d[i+1]}
                                  + (DATA_W+1)'(1)) >> 1);
            out_d[i+1] = pair_now ? avg_d[i] : (odd_now ? avg_q[i] : ycc_q[i+1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
            for (int i = 0; i < 2; i++) avg_q[i] <= '0;
            for (int i = 0; i < 3; i++) out_q[i] <= '0;
        end else begin
            parity_q <= parity_d;
            for (int i = 0; i < 2; i++) avg_q[i] <= avg_d[i];
            for (int i = 0; i < 3; i++) out_q[i] <= out_d[i];
        end
    end

    assign post_img_Y  = out_q[0];
    assign post_img_Cb = out_q[1];
    assign post_img_Cr = out_q[2];
`else
    assign post_img_Y  = ycc_q[0];
    assign post_img_Cb = ycc_q[1];
    assign post_img_Cr = ycc_q[2];
`endif

    assign post_img_vsync = vs_q[LAT-1];
    assign post_img_href  = hs_q[LAT-1];
    assign mode_active    = mode_active_q;

endmodule

// File: tb/tb_vip_rgb_ycbcr_conv.sv
// Randomized bench for vip_rgb_ycbcr_conv: per-edge input log plus an arithmetic
// reference model; honours YCBCR_422_EN for latency and chroma pairing.
`timescale 1ns/1ps
module tb_vip_rgb_ycbcr_conv;
    localparam int DW = 8;
`ifdef YCBCR_422_EN
    localparam int LAT = 4;
    localparam bit AVG = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit AVG = 1'b0;
`endif
    localparam int MAXV = (1 << DW) - 1;
    localparam int NMAX = 4096;

    logic          clk = 1'b0;
    logic          rst, mode, vsync, href;
    logic [DW-1:0] red, green, blue;
    logic          o_vsync, o_href, o_mact;
    logic [DW-1:0] o_y, o_cb, o_cr;

    always #5 clk = ~clk;

    vip_rgb_ycbcr_conv #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .per_img_vsync(vsync), .per_img_href(href),
        .per_img_red(red), .per_img_green(green), .per_img_blue(blue),
        .post_img_vsync(o_vsync), .post_img_href(o_href),
        .post_img_Y(o_y), .post_img_Cb(o_cb), .post_img_Cr(o_cr),
        .mode_active(o_mact)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = -1;

    // Log of what the DUT sampled at each rising edge, plus model frame state.
    bit rst_a [NMAX];
    bit vs_a  [NMAX];
    bit hs_a  [NMAX];
    bit md_a  [NMAX];
    bit rise_a[NMAX];
    bit used_a[NMAX];
    int r_a   [NMAX];
    int g_a   [NMAX];
    int b_a   [NMAX];
    int pos_a [NMAX];
    bit prev_vs, fmode, mact;
    bit vs_cur, mode_cur;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %0d, expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    // Full-range conversion straight from the published integer coefficients.
    function automatic int conv(input bit m, input int ch, input int rr, input int gg, input int bb);
        int kr, kg, kb, s;
        if (ch == 0) begin
            kr = m ? 54 : 77;    kg = m ? 183 : 150;  kb = m ? 19 : 29;
        end else if (ch == 1) begin
            kr = m ? -29 : -43;  kg = m ? -99 : -85;  kb = 128;
        end else begin
            kr = 128;            kg = m ? -116 : -107; kb = m ? -12 : -21;
        end
        s = kr * rr + kg * gg + kb * bb + 128;
        if (ch != 0) s = s + (1 << (DW - 1)) * 256;
        s = s >>> 8;
        if (s < 0) s = 0;
        if (s > MAXV) s = MAXV;
        return s;
    endfunction

    function automatic int rcomp();
        int sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return 0;
        if (sel == 1) return MAXV;
        return $urandom_range(0, MAXV);
    endfunction

    task automatic tick(input bit r_i, input bit v_i, input bit h_i, input bit m_i,
                        input int rr, input int gg, input int bb);
        int  k, j, ey, ecb, ecr;
        bit  flushed, rise, ev, eh;
        rst = r_i; vsync = v_i; href = h_i; mode = m_i;
        red = DW'(rr); green = DW'(gg); blue = DW'(bb);
        @(posedge clk);
        edge_n++;
        if (edge_n >= NMAX) begin
            $display("FAIL log_overflow edge %0d: got %0d, expected %0d", edge_n, edge_n, NMAX - 1);
            $fatal(1, "log overflow");
        end
        rst_a[edge_n] = r_i; vs_a[edge_n] = v_i; hs_a[edge_n] = h_i; md_a[edge_n] = m_i;
        r_a[edge_n] = rr; g_a[edge_n] = gg; b_a[edge_n] = bb;
        rise = v_i && !prev_vs;
        rise_a[edge_n] = rise;
        used_a[edge_n] = rise ? m_i : fmode;
        prev_vs = r_i ? 1'b0 : v_i;
        fmode   = r_i ? 1'b0 : used_a[edge_n];
        pos_a[edge_n] = (edge_n > 0 && h_i && hs_a[edge_n-1] && !rst_a[edge_n-1])
                        ? pos_a[edge_n-1] + 1 : 0;
        @(negedge clk);
        k = edge_n - LAT + 1;
        flushed = (k < 0);
        for (int i = (k < 0) ? 0 : k; i <= edge_n; i++) if (rst_a[i]) flushed = 1'b1;
        ev = flushed ? 1'b0 : vs_a[k];
        eh = flushed ? 1'b0 : hs_a[k];
        if (rst_a[edge_n]) mact = 1'b0;
        else if (!flushed && rise_a[k]) mact = used_a[k];
        check_eq("no_x", 32'($isunknown({o_vsync, o_href, o_mact, o_y, o_cb, o_cr})), 0);
        check_eq("vsync", 32'(o_vsync), 32'(ev));
        check_eq("href", 32'(o_href), 32'(eh));
        check_eq("mode_active", 32'(o_mact), 32'(mact));
        if (eh) begin
            ey  = conv(used_a[k], 0, r_a[k], g_a[k], b_a[k]);
            ecb = conv(used_a[k], 1, r_a[k], g_a[k], b_a[k]);
            ecr = conv(used_a[k], 2, r_a[k], g_a[k], b_a[k]);
            j = k;
            if (AVG) begin
                if (pos_a[k] % 2 == 1) j = k - 1;
                else if (hs_a[k+1]) j = k + 1;
            end
            if (j != k) begin
                ecb = (ecb + conv(used_a[j], 1, r_a[j], g_a[j], b_a[j]) + 1) / 2;
                ecr = (ecr + conv(used_a[j], 2, r_a[j], g_a[j], b_a[j]) + 1) / 2;
            end
            check_eq("Y", 32'(o_y), 32'(ey));
            check_eq("Cb", 32'(o_cb), 32'(ecb));
            check_eq("Cr", 32'(o_cr), 32'(ecr));
        end
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) tick(1'b0, vs_cur, 1'b0, mode_cur, rcomp(), rcomp(), rcomp());
    endtask

    task automatic pix(input int rr, input int gg, input int bb);
        tick(1'b0, vs_cur, 1'b1, mode_cur, rr, gg, bb);
    endtask

    initial begin
        prev_vs = 0; fmode = 0; mact = 0; vs_cur = 0; mode_cur = 0;
        // Reset held with random inputs on every pin.
        for (int i = 0; i < 5; i++)
            tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rcomp(), rcomp(), rcomp());
        idle(3);
        // BT.601 frame with a mid-frame mode change that must be ignored.
        vs_cur = 1; mode_cur = 0; idle(2);
        pix(MAXV, MAXV, MAXV); pix(MAXV, 0, 0); pix(0, 0, MAXV); pix(MAXV, 0, 0);
        idle(2); mode_cur = 1;
        pix(MAXV, 0, 0); pix(0, 0, MAXV); pix(0, MAXV, 0);
        idle(2); vs_cur = 0; idle(3);
        // BT.709 frame: 2-pixel line then 3-pixel line.
        vs_cur = 1; idle(1);
        pix(MAXV, 0, 0); pix(0, 0, MAXV); idle(1);
        pix(MAXV, 0, 0); pix(0, 0, MAXV); pix(MAXV, 0, 0); idle(1);
        vs_cur = 0; idle(4);
        // Random frames, random mode wiggling, one reset pulse mid-line with vsync high.
        for (int f = 0; f < 8; f++) begin
            mode_cur = 1'($urandom_range(0, 1));
            vs_cur = 1;
            for (int l = 0; l < 4; l++) begin
                idle($urandom_range(0, 3));
                for (int p = 0, len = $urandom_range(1, 9); p < len; p++) begin
                    mode_cur = 1'($urandom_range(0, 1));
                    if (f == 3 && l == 1 && p == 2) begin
                        tick(1'b1, 1'b1, 1'b1, mode_cur, rcomp(), rcomp(), rcomp());
                        tick(1'b1, 1'b1, 1'b1, mode_cur, rcomp(), rcomp(), rcomp());
                    end
                    pix(rcomp(), rcomp(), rcomp());
                end
            end
            idle(1);
            vs_cur = 0;
            idle($urandom_range(2, 5));
        end
        idle(LAT + 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vip_rgb_ycbcr_conv.md
# vip_rgb_ycbcr_conv

Parametrised RGB-to-YCbCr colour-space converter for the video image processing (VIP) pipeline. It is the next generation of the fixed 8-bit RGB888-to-YCbCr444 stage and sits between the camera/RGB source and the luma/chroma processing blocks. It adds configurable component width, run-time selection between BT.601 and BT.709 with per-frame mode latching, output saturation, and optional 4:2:2 chroma pair averaging.

## Interface
- DATA_W, 8: component width for R, G, B, Y, Cb and Cr; legal range 8..12.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  colour standard: 0 = BT.601 full range, 1 = BT.709 full range. Sampled only at frame start.
- per_img_vsync  in  1  input frame valid, held high for the whole frame.
- per_img_href  in  1  input pixel valid; high for each contiguous line.
- per_img_red / per_img_green / per_img_blue  in  DATA_W each  input pixel components.
- post_img_vsync  out  1  per_img_vsync delayed by LAT.
- post_img_href  out  1  per_img_href delayed by LAT.
- post_img_Y / post_img_Cb / post_img_Cr  out  DATA_W each  converted components.
- mode_active  out  1  mode latched for the current frame.

## Operation
- Coefficients use 8 fractional bits.
- BT.601: Y = 77R + 150G + 29B; Cb = −43R − 85G + 128B; Cr = 128R − 107G − 21B.
- BT.709: Y = 54R + 183G + 19B; Cb = −29R − 99G + 128B; Cr = 128R − 116G − 12B.
- Chroma adds an offset of 2^(DATA_W−1)·256. Every channel adds 128 for rounding, then shifts right arithmetically by 8.
- Signed intermediates are DATA_W+11 bits. Results are clamped to [0, 2^DATA_W − 1].
- Mode latch: on the rising edge of per_img_vsync (previous sample 0, current sample 1), mode is captured into a frame register. All pixels of that frame use the latched mode; mode changes mid-frame are ignored.
- mode_active updates at the same cycle the frame's first vsync high reaches the output, so it aligns with post_img_vsync.
- Pixel data is registered in stage 0 whether or not href is high. Output data is don't-care while post_img_href = 0, but it must be deterministic (no X after reset).

## Timing
- Base pipeline, LAT = 3: stage 1 multiplies, stage 2 sums, stage 3 adds offset/rounding and clamps.
- post_img_vsync and post_img_href pass through a LAT-deep shift register that matches the data pipeline exactly.
- Throughput: one pixel per clock. No backpressure.
- Reset: all pipeline registers, the sync delay line, all outputs and mode_active go to 0 on the first clk edge with rst = 1.
- Reset asserted mid-frame: the pipeline is flushed and no partial pixels emerge. The next per_img_vsync rising edge after reset is a new frame start.
- If per_img_vsync is already high when rst deasserts, that counts as a rising edge on the first post-reset cycle.

## Configuration
- YCBCR_422_EN defined: adds one averaging stage, so LAT = 4.
- Pairing: a parity bit clears on each per-line href rising edge (at the stage-3 output). It marks pixels as even or odd within the line.
- An even pixel is held one cycle. If the next cycle holds an odd pixel of the same line, both pixels output Cb = (Cb_e + Cb_o + 1) >> 1 and Cr likewise, computed on clamped values. Y is unchanged.
- An even pixel followed by href low (odd line width or a gap) is emitted with its own Cb/Cr.
- Output stays in the 4:4:4 container. Downstream decimation is the consumer's job.
- Undefined: no averaging stage; LAT = 3; output is pure 4:4:4.

## Test plan
- Reset check: rst held 5 cycles with random inputs -> all outputs and mode_active = 0; no X on any output.
- White pixel, BT.601, DATA_W = 8: R = G = B = 255 -> Y = 255, Cb = 128, Cr = 128, exactly LAT cycles after the input href.
- Pure red, BT.601: (255, 0, 0) -> Y = 77, Cb = 85, Cr clamps 256 → 255. Same pixel in BT.709 -> Y = 54, Cb = 99, Cr = 255.
- Mode latch: frame started with mode = 0, mode toggled to 1 mid-frame -> whole frame uses BT.601; the next frame uses BT.709; mode_active flips aligned with post_img_vsync rising.
- YCBCR_422_EN, BT.601, line of red then blue -> both pixels Cb = 170, Cr = 181; Y = 77 then 29. A 3-pixel line -> the third pixel carries its own Cb/Cr.
- 640×480 frame against the golden YCbCr file plus rst pulse mid-line -> zero mismatches, and post_img_href count = 640 per line.
